// File: rtl/wb_gpio_irq.sv
// Wishbone classic-cycle GPIO controller: synchronised inputs, atomic set/clear of
// outputs and per-pin edge/level interrupts with write-1-to-clear status.
module wb_gpio_irq #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [3:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_dir_o,
    output logic             irq_o
);

    typedef enum logic [3:0] {
        REG_DIN        = 4'd0,
        REG_DOUT       = 4'd1,
        REG_DIR        = 4'd2,
        REG_SET        = 4'd3,
        REG_CLR        = 4'd4,
        REG_IRQ_EN     = 4'd5,
        REG_IRQ_TYPE   = 4'd6,
        REG_IRQ_POL    = 4'd7,
        REG_IRQ_STATUS = 4'd8
    } reg_e;

    localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_type;
    logic [WIDTH-1:0] irq_pol;
    logic [WIDTH-1:0] irq_status;
    logic [WIDTH-1:0] status_next;
    logic [WIDTH-1:0] wr_mask;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_ev;
    logic [WIDTH-1:0] level_ev;
    logic [WIDTH-1:0] irq_event;
    logic [31:0]      sel_mask;
    logic [31:0]      rdata;
    logic [2:0]       arm_cnt;
    logic             armed;
    logic             access;
    logic             wr;
    logic             unused_bits;

    always_comb begin
        sel_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        wr_mask  = sel_mask[WIDTH-1:0];
        wr_data  = wb_dat_i[WIDTH-1:0] & wr_mask;
    end

    assign unused_bits = ^{sel_mask, wb_dat_i};

    // A new access is only accepted while ack is low, giving a 2-cycle minimum per access.
    assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr     = access & wb_we_i;

    assign din   = sync_q[SYNC_STAGES-1];
    assign armed = (arm_cnt == ARM_CYCLES);

    always_comb begin
        rise      = din & ~prev;
        fall      = ~din & prev;
        edge_ev   = armed ? ((rise & irq_pol) | (fall & ~irq_pol)) : '0;
        level_ev  = ~(din ^ irq_pol);
        irq_event = (irq_type & edge_ev) | (~irq_type & level_ev);
    end

    // W1C is applied first so a coincident event still leaves the bit set.
    always_comb begin
        status_next = irq_status;
        if (wr && wb_adr_i == REG_IRQ_STATUS) begin
            status_next = irq_status & ~wr_data;
        end
        status_next = status_next | irq_event;
    end

    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            REG_DIN:        rdata[WIDTH-1:0] = din;
            REG_DOUT:       rdata[WIDTH-1:0] = dout;
            REG_DIR:        rdata[WIDTH-1:0] = dir;
            REG_IRQ_EN:     rdata[WIDTH-1:0] = irq_en;
            REG_IRQ_TYPE:   rdata[WIDTH-1:0] = irq_type;
            REG_IRQ_POL:    rdata[WIDTH-1:0] = irq_pol;
            REG_IRQ_STATUS: rdata[WIDTH-1:0] = irq_status;
            default:        rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prev       <= '0;
            arm_cnt    <= '0;
            dout       <= RESET_OUT;
            dir        <= '0;
            irq_en     <= '0;
            irq_type   <= '0;
            irq_pol    <= '0;
            irq_status <= '0;
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
            irq_o      <= 1'b0;
        end else begin
            prev       <= din;
            irq_status <= status_next;
            irq_o      <= |(irq_status & irq_en);
            wb_ack_o   <= access;
            wb_dat_o   <= (access && !wb_we_i) ? rdata : '0;
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
            if (wr) begin
                case (wb_adr_i)
                    REG_DOUT:     dout     <= (dout & ~wr_mask) | wr_data;
                    REG_DIR:      dir      <= (dir & ~wr_mask) | wr_data;
                    REG_SET:      dout     <= dout | wr_data;
                    REG_CLR:      dout     <= dout & ~wr_data;
                    REG_IRQ_EN:   irq_en   <= (irq_en & ~wr_mask) | wr_data;
                    REG_IRQ_TYPE: irq_type <= (irq_type & ~wr_mask) | wr_data;
                    REG_IRQ_POL:  irq_pol  <= (irq_pol & ~wr_mask) | wr_data;
                    default:      ;
                endcase
            end
        end
    end

    assign gpio_o     = dout;
    assign gpio_dir_o = dir;

endmodule
